// File: rtl/mont_exp_bit_server.sv
// mont_exp_bit_server: loads a wide exponent block by block into a shadow
// buffer and serves it bit by bit, MSB first, to the Montgomery accumulator.
// The shadow buffer lets the next exponent load while the current one is
// still being served, so back-to-back exponents stream without a gap.
module mont_exp_bit_server #(
    parameter int REGISTER_SIZE = 32,
    parameter int BITS_IN_EXP   = 2048
) (
    input  logic                           clk_in,
    input  logic                           rst_in,
    input  logic [REGISTER_SIZE-1:0]       exp_block_in,
    input  logic                           exp_valid_in,
    output logic                           exp_ready_out,
    input  logic                           consumed_n_in,
    output logic                           n_bit_out,
    output logic                           n_bit_valid_out,
    output logic [$clog2(BITS_IN_EXP)-1:0] bit_idx_out,
    output logic                           exp_done_out,
    output logic                           underrun_out
);

    localparam int NB     = BITS_IN_EXP / REGISTER_SIZE;
    localparam int IDX_W  = $clog2(BITS_IN_EXP);
    localparam int LCNT_W = (NB > 1) ? $clog2(NB) : 1;

    localparam logic [IDX_W-1:0]  TOP_IDX  = IDX_W'(BITS_IN_EXP - 1);
    localparam logic [LCNT_W-1:0] LAST_BLK = LCNT_W'(NB - 1);

    typedef enum logic {FILL, FULL}  load_state_t;
    typedef enum logic {IDLE, SERVE} serve_state_t;

    load_state_t  load_state,  load_next;
    serve_state_t serve_state, serve_next;

    logic [BITS_IN_EXP-1:0] shadow_reg;
    logic [BITS_IN_EXP-1:0] active_reg;
    logic [LCNT_W-1:0]      load_cnt;
    logic [IDX_W-1:0]       bit_idx;
    logic                   done_reg;
    logic                   underrun_reg;

    logic accept;
    logic last_consume;
    logic transfer;

    // A block is taken only while the shadow is filling; valid in FULL is ignored.
    assign accept = (load_state == FILL) && exp_valid_in;

    // The consume of bit 0 finishes the exponent currently being served.
    assign last_consume = (serve_state == SERVE) && consumed_n_in && (bit_idx == '0);

    // Decide the shadow-to-active transfer and the next state of both FSMs.
    always_comb begin
        transfer   = 1'b0;
        load_next  = load_state;
        serve_next = serve_state;

        if (load_state == FULL) begin
            if (serve_state == IDLE) begin
                transfer = 1'b1;
            end else if (last_consume) begin
                transfer = 1'b1;
            end
        end

        case (load_state)
            FILL: if (accept && (load_cnt == LAST_BLK)) load_next = FULL;
            FULL: if (transfer) load_next = FILL;
            default: load_next = FILL;
        endcase

        if (transfer) begin
            serve_next = SERVE;
        end else if (last_consume) begin
            serve_next = IDLE;
        end
    end

    // State registers for the load and serve FSMs.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            load_state  <= FILL;
            serve_state <= IDLE;
        end else begin
            load_state  <= load_next;
            serve_state <= serve_next;
        end
    end

    // Block position counter: wraps to 0 after the final block of an exponent.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            load_cnt <= '0;
        end else if (accept) begin
            if (load_cnt == LAST_BLK) begin
                load_cnt <= '0;
            end else begin
                load_cnt <= load_cnt + LCNT_W'(1);
            end
        end
    end

    // Shadow storage: each accepted block lands at its position, block 0 at the bottom.
    always_ff @(posedge clk_in) begin
        if (accept) begin
            for (int b = 0; b < NB; b++) begin
                if (load_cnt == LCNT_W'(b)) begin
                    shadow_reg[b*REGISTER_SIZE +: REGISTER_SIZE] <= exp_block_in;
                end
            end
        end
    end

    // Active storage: takes a full copy of the shadow on every transfer.
    always_ff @(posedge clk_in) begin
        if (transfer) begin
            active_reg <= shadow_reg;
        end
    end

    // Bit index, completion pulse and sticky underrun flag.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            bit_idx      <= '0;
            done_reg     <= 1'b0;
            underrun_reg <= 1'b0;
        end else begin
            done_reg <= last_consume;
            if (consumed_n_in && (serve_state == IDLE)) begin
                underrun_reg <= 1'b1;
            end
            if (transfer) begin
                bit_idx <= TOP_IDX;
            end else if ((serve_state == SERVE) && consumed_n_in && (bit_idx != '0)) begin
                bit_idx <= bit_idx - IDX_W'(1);
            end
        end
    end

    assign exp_ready_out   = (load_state == FILL);
    assign n_bit_valid_out = (serve_state == SERVE);
    assign n_bit_out       = (serve_state == SERVE) && active_reg[bit_idx];
    assign bit_idx_out     = bit_idx;
    assign exp_done_out    = done_reg;
    assign underrun_out    = underrun_reg;

endmodule

// File: tb/tb_mont_exp_bit_server.sv
// tb_mont_exp_bit_server: directed tests of the exponent bit server with a
// 64-bit exponent split into two 32-bit blocks.
module tb_mont_exp_bit_server;

    localparam int RS  = 32;
    localparam int BIE = 64;

    logic          clk_in = 1'b0;
    logic          rst_in;
    logic [RS-1:0] exp_block_in;
    logic          exp_valid_in;
    logic          exp_ready_out;
    logic          consumed_n_in;
    logic          n_bit_out;
    logic          n_bit_valid_out;
    logic [5:0]    bit_idx_out;
    logic          exp_done_out;
    logic          underrun_out;

    int tests_run    = 0;
    int tests_failed = 0;

    mont_exp_bit_server #(
        .REGISTER_SIZE (RS),
        .BITS_IN_EXP   (BIE)
    ) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .exp_block_in    (exp_block_in),
        .exp_valid_in    (exp_valid_in),
        .exp_ready_out   (exp_ready_out),
        .consumed_n_in   (consumed_n_in),
        .n_bit_out       (n_bit_out),
        .n_bit_valid_out (n_bit_valid_out),
        .bit_idx_out     (bit_idx_out),
        .exp_done_out    (exp_done_out),
        .underrun_out    (underrun_out)
    );

    // Free-running clock, 10 ns period.
    always #5 clk_in = ~clk_in;

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_reset();
        rst_in        = 1'b1;
        exp_valid_in  = 1'b0;
        exp_block_in  = '0;
        consumed_n_in = 1'b0;
        tick();
        tick();
        rst_in = 1'b0;
    endtask

    // Present one block and hold it until the DUT accepts it (bounded wait).
    task automatic load_block(input logic [RS-1:0] blk);
        logic ready_now;
        bit   ok;
        ok           = 1'b0;
        exp_block_in = blk;
        exp_valid_in = 1'b1;
        for (int i = 0; i < 300; i++) begin
            ready_now = exp_ready_out;
            tick();
            if (ready_now) begin
                ok = 1'b1;
                break;
            end
        end
        exp_valid_in = 1'b0;
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("[TB] FAIL load_block timeout: block %h not accepted, required accept within 300 cycles", blk);
        end
    endtask

    task automatic load_exp(input logic [63:0] v);
        load_block(v[31:0]);
        load_block(v[63:32]);
    endtask

    task automatic test_reset();
        rst_in        = 1'b1;
        exp_valid_in  = 1'b0;
        exp_block_in  = '0;
        consumed_n_in = 1'b0;
        tick();
        tick();
        tests_run++;
        if (exp_ready_out !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset ready: got %b want 1", exp_ready_out); end
        tests_run++;
        if (n_bit_valid_out !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset valid: got %b want 0", n_bit_valid_out); end
        tests_run++;
        if (underrun_out !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset underrun: got %b want 0", underrun_out); end
        tests_run++;
        if (exp_done_out !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset done: got %b want 0", exp_done_out); end
        tests_run++;
        if (n_bit_out !== 1'b0 || bit_idx_out !== 6'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset bit/idx: got %b/%0d want 0/0", n_bit_out, bit_idx_out);
        end
        rst_in = 1'b0;
    endtask

    task automatic test_load_serve();
        logic [63:0] v;
        logic        exp_bit;
        v = 64'h80000000_00000001;
        do_reset();
        load_exp(v);
        tests_run++;
        if (n_bit_valid_out !== 1'b0 || exp_ready_out !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL load_full: valid/ready got %b/%b want 0/0", n_bit_valid_out, exp_ready_out);
        end
        tick();
        for (int i = 0; i < 64; i++) begin
            exp_bit = v[63-i];
            tests_run++;
            if (n_bit_valid_out !== 1'b1 || bit_idx_out !== 6'(63-i) || n_bit_out !== exp_bit || exp_done_out !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL serve step %0d: valid/idx/bit/done got %b/%0d/%b/%b want 1/%0d/%b/0",
                         i, n_bit_valid_out, bit_idx_out, n_bit_out, exp_done_out, 63-i, exp_bit);
            end
            consumed_n_in = 1'b1;
            tick();
            consumed_n_in = 1'b0;
        end
        tests_run++;
        if (exp_done_out !== 1'b1 || n_bit_valid_out !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL serve end: done/valid got %b/%b want 1/0", exp_done_out, n_bit_valid_out);
        end
        tick();
        tests_run++;
        if (exp_done_out !== 1'b0) begin tests_failed++; $display("[TB] FAIL done pulse width: got %b want 0", exp_done_out); end
    endtask

    task automatic test_back_to_back();
        logic exp_bit;
        logic exp_done;
        do_reset();
        load_exp(64'hFFFFFFFF_FFFFFFFF);
        load_exp(64'h00000000_00000000);
        for (int i = 0; i < 128; i++) begin
            exp_bit  = (i < 64);
            exp_done = (i == 64);
            tests_run++;
            if (n_bit_valid_out !== 1'b1 || bit_idx_out !== 6'(63 - (i % 64)) || n_bit_out !== exp_bit || exp_done_out !== exp_done) begin
                tests_failed++;
                $display("[TB] FAIL b2b step %0d: valid/idx/bit/done got %b/%0d/%b/%b want 1/%0d/%b/%b",
                         i, n_bit_valid_out, bit_idx_out, n_bit_out, exp_done_out, 63 - (i % 64), exp_bit, exp_done);
            end
            consumed_n_in = 1'b1;
            tick();
        end
        consumed_n_in = 1'b0;
        tests_run++;
        if (exp_done_out !== 1'b1 || n_bit_valid_out !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL b2b end: done/valid got %b/%b want 1/0", exp_done_out, n_bit_valid_out);
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] a, b, c, word;
        logic        exp_bit, exp_done, exp_ready, ready_now, offered;
        int          c_idx;
        a = 64'hDEADBEEF_01234567;
        b = 64'h0F0F0F0F_F0F0F0F0;
        c = 64'h80000001_12345678;
        do_reset();
        load_exp(a);
        load_exp(b);
        c_idx = 0;
        for (int i = 0; i < 192; i++) begin
            word      = (i < 64) ? a : ((i < 128) ? b : c);
            exp_bit   = word[63 - (i % 64)];
            exp_done  = (i == 64) || (i == 128);
            exp_ready = (i == 64) || (i == 65) || (i >= 128);
            tests_run++;
            if (n_bit_valid_out !== 1'b1 || bit_idx_out !== 6'(63 - (i % 64)) || n_bit_out !== exp_bit ||
                exp_done_out !== exp_done || exp_ready_out !== exp_ready) begin
                tests_failed++;
                $display("[TB] FAIL bp step %0d: valid/idx/bit/done/ready got %b/%0d/%b/%b/%b want 1/%0d/%b/%b/%b",
                         i, n_bit_valid_out, bit_idx_out, n_bit_out, exp_done_out, exp_ready_out,
                         63 - (i % 64), exp_bit, exp_done, exp_ready);
            end
            offered      = (c_idx < 2);
            exp_valid_in = offered;
            exp_block_in = (c_idx == 0) ? c[31:0] : c[63:32];
            consumed_n_in = 1'b1;
            ready_now = exp_ready_out;
            tick();
            if (ready_now && offered) c_idx++;
        end
        consumed_n_in = 1'b0;
        exp_valid_in  = 1'b0;
        tests_run++;
        if (exp_done_out !== 1'b1 || n_bit_valid_out !== 1'b0 || c_idx != 2) begin
            tests_failed++;
            $display("[TB] FAIL bp end: done/valid/blocks got %b/%b/%0d want 1/0/2", exp_done_out, n_bit_valid_out, c_idx);
        end
    endtask

    task automatic test_simultaneous();
        logic [63:0] a, b;
        a = 64'h12345678_9ABCDEF0;
        b = 64'hC0000000_00000003;
        do_reset();
        load_exp(a);
        load_block(b[31:0]);
        for (int i = 0; i < 63; i++) begin
            consumed_n_in = 1'b1;
            tick();
        end
        consumed_n_in = 1'b0;
        tests_run++;
        if (bit_idx_out !== 6'd0 || exp_ready_out !== 1'b1 || n_bit_out !== a[0]) begin
            tests_failed++;
            $display("[TB] FAIL simul pre: idx/ready/bit got %0d/%b/%b want 0/1/%b", bit_idx_out, exp_ready_out, n_bit_out, a[0]);
        end
        exp_block_in  = b[63:32];
        exp_valid_in  = 1'b1;
        consumed_n_in = 1'b1;
        tick();
        exp_valid_in  = 1'b0;
        consumed_n_in = 1'b0;
        tests_run++;
        if (exp_done_out !== 1'b1 || n_bit_valid_out !== 1'b0 || exp_ready_out !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL simul bubble: done/valid/ready got %b/%b/%b want 1/0/0", exp_done_out, n_bit_valid_out, exp_ready_out);
        end
        tick();
        tests_run++;
        if (n_bit_valid_out !== 1'b1 || bit_idx_out !== 6'd63 || n_bit_out !== b[63] || exp_done_out !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL simul resume: valid/idx/bit/done got %b/%0d/%b/%b want 1/63/%b/0",
                     n_bit_valid_out, bit_idx_out, n_bit_out, exp_done_out, b[63]);
        end
    endtask

    task automatic test_underrun();
        do_reset();
        consumed_n_in = 1'b1;
        tick();
        consumed_n_in = 1'b0;
        tests_run++;
        if (underrun_out !== 1'b1 || n_bit_valid_out !== 1'b0 || bit_idx_out !== 6'd0) begin
            tests_failed++;
            $display("[TB] FAIL underrun set: underrun/valid/idx got %b/%b/%0d want 1/0/0", underrun_out, n_bit_valid_out, bit_idx_out);
        end
        load_exp(64'h00000000_00000001);
        tick();
        for (int i = 0; i < 64; i++) begin
            consumed_n_in = 1'b1;
            tick();
        end
        consumed_n_in = 1'b0;
        tests_run++;
        if (underrun_out !== 1'b1 || exp_done_out !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL underrun sticky: underrun/done got %b/%b want 1/1", underrun_out, exp_done_out);
        end
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
        tests_run++;
        if (underrun_out !== 1'b0) begin tests_failed++; $display("[TB] FAIL underrun clear: got %b want 0", underrun_out); end
    endtask

    task automatic test_reset_mid_service();
        logic [63:0] d;
        d = 64'hA5000000_0000005A;
        do_reset();
        load_exp(64'hFFFF0000_FFFF0000);
        load_exp(64'h0000FFFF_0000FFFF);
        for (int i = 0; i < 10; i++) begin
            consumed_n_in = 1'b1;
            tick();
        end
        consumed_n_in = 1'b0;
        tests_run++;
        if (bit_idx_out !== 6'd53 || exp_ready_out !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL midrst pre: idx/ready got %0d/%b want 53/0", bit_idx_out, exp_ready_out);
        end
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
        tests_run++;
        if (exp_ready_out !== 1'b1 || n_bit_valid_out !== 1'b0 || n_bit_out !== 1'b0 || bit_idx_out !== 6'd0 ||
            exp_done_out !== 1'b0 || underrun_out !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL midrst outputs: ready/valid/bit/idx/done/underrun got %b/%b/%b/%0d/%b/%b want 1/0/0/0/0/0",
                     exp_ready_out, n_bit_valid_out, n_bit_out, bit_idx_out, exp_done_out, underrun_out);
        end
        tick();
        tests_run++;
        if (n_bit_valid_out !== 1'b0 || exp_ready_out !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL midrst discard: valid/ready got %b/%b want 0/1", n_bit_valid_out, exp_ready_out);
        end
        load_exp(d);
        tick();
        tests_run++;
        if (n_bit_valid_out !== 1'b1 || bit_idx_out !== 6'd63 || n_bit_out !== d[63]) begin
            tests_failed++;
            $display("[TB] FAIL midrst fresh: valid/idx/bit got %b/%0d/%b want 1/63/%b", n_bit_valid_out, bit_idx_out, n_bit_out, d[63]);
        end
        consumed_n_in = 1'b1;
        tick();
        consumed_n_in = 1'b0;
        tests_run++;
        if (bit_idx_out !== 6'd62 || n_bit_out !== d[62]) begin
            tests_failed++;
            $display("[TB] FAIL midrst advance: idx/bit got %0d/%b want 62/%b", bit_idx_out, n_bit_out, d[62]);
        end
    endtask

    // Run every scenario in order, then report.
    initial begin
        rst_in        = 1'b1;
        exp_valid_in  = 1'b0;
        exp_block_in  = '0;
        consumed_n_in = 1'b0;
        test_reset();
        test_load_serve();
        test_back_to_back();
        test_backpressure();
        test_simultaneous();
        test_underrun();
        test_reset_mid_service();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/mont_exp_bit_server.md
# mont_exp_bit_server

Exponent-bit scheduler for `mont_accumulator`. It accepts a BITS_IN_EXP-bit exponent as REGISTER_SIZE-wide blocks and presents it one bit at a time, MSB first, on the accumulator's `n_bit_in`. It advances one bit on every `consumed_n_out` pulse from the accumulator. A shadow buffer lets the next exponent load while the current one is being served, so back-to-back exponentiations run without a bubble on the bit stream.

## Interface
Parameters:
- REGISTER_SIZE, 32, block width of the exponent stream
- BITS_IN_EXP, 2048, exponent width; must be a multiple of REGISTER_SIZE (NB = BITS_IN_EXP/REGISTER_SIZE blocks)

Ports:
- clk_in  input  1  single clock
- rst_in  input  1  reset, synchronous, active-high
- exp_block_in  input  REGISTER_SIZE  exponent block, least-significant block first
- exp_valid_in  input  1  exp_block_in valid
- exp_ready_out  output  1  shadow buffer can accept a block; a transfer occurs when valid && ready
- consumed_n_in  input  1  single-cycle pulse from the accumulator: current bit used, advance
- n_bit_out  output  1  current exponent bit, to the accumulator's n_bit_in
- n_bit_valid_out  output  1  n_bit_out holds a live bit
- bit_idx_out  output  $clog2(BITS_IN_EXP)  index of the bit on n_bit_out (BITS_IN_EXP-1 down to 0)
- exp_done_out  output  1  one-cycle pulse: last bit (index 0) consumed
- underrun_out  output  1  sticky: consumed_n_in arrived while n_bit_valid_out=0

## Operation
- Storage: shadow register (BITS_IN_EXP bits) plus load counter 0..NB-1; active register (BITS_IN_EXP bits) plus bit counter.
- Load FSM, states FILL and FULL:
  - FILL: exp_ready_out=1. Each accepted block is written at block position load_cnt, so block 0 lands in bits [REGISTER_SIZE-1:0].
  - When block NB-1 is accepted, load_cnt returns to 0 and the FSM moves to FULL.
  - FULL: exp_ready_out=0. The FSM leaves FULL on the cycle the shadow is transferred to active, then returns to FILL.
- Serve FSM, states IDLE and SERVE:
  - IDLE: n_bit_valid_out=0, n_bit_out=0, bit_idx_out=0.
  - Transfer happens when load=FULL and (serve=IDLE, or serve=SERVE with consumed_n_in on bit index 0). It copies shadow to active and sets bit_idx to BITS_IN_EXP-1. Serve goes to or stays in SERVE.
  - SERVE: n_bit_out = active[bit_idx]. On consumed_n_in with bit_idx>0, decrement bit_idx.
  - On consumed_n_in with bit_idx=0: pulse exp_done_out. Serve then either transfers (above) or goes to IDLE.
- Simultaneous events:
  - Final block accepted and last-bit consume in the same cycle: load reaches FULL at that edge, but the transfer happens the next cycle. Result is a one-cycle bubble.
  - Consume on a non-final bit while load=FULL: just advance; no transfer.
- consumed_n_in while serve=IDLE: ignored for data, sets underrun_out. Only rst_in clears underrun_out.
- exp_valid_in while exp_ready_out=0: ignored, no side effect.
- Reset mid-operation: both FSMs return to FILL/IDLE and counters clear. A partially loaded or partially served exponent is discarded. Storage contents are don't-care.

## Timing
- Reset values: exp_ready_out=1, n_bit_valid_out=0, n_bit_out=0, bit_idx_out=0, exp_done_out=0, underrun_out=0.
- All outputs are registered or decoded directly from registered state; no combinational path from consumed_n_in or exp_valid_in to any output.
- Load latency: last block accepted at edge E. Load=FULL after E. If serve is IDLE, the transfer is at E+1 and n_bit_valid_out=1 with bit BITS_IN_EXP-1 after E+1.
- Advance latency: consume at edge E means n_bit_out shows the next bit after E.
- Back-to-back: a shadow already FULL when the index-0 consume occurs gives zero bubble. n_bit_valid_out stays 1, and bit_idx_out goes from 0 to BITS_IN_EXP-1 on that edge, with exp_done_out high for that cycle.
- Throughput: up to one consume per cycle; one block per cycle while in FILL.

## Test plan
Bench uses BITS_IN_EXP=64, REGISTER_SIZE=32 unless noted.
- Reset: hold rst_in 2 cycles -> exp_ready_out=1, n_bit_valid_out=0, underrun_out=0, exp_done_out=0.
- Load 0x00000001 then 0x80000000, then pulse consume 64 times -> bits read 1, 62×0, 1. bit_idx_out goes 63..0. exp_done_out pulses exactly once, on the 64th consume. n_bit_valid_out=0 afterwards.
- Back-to-back: load A=0xFFFFFFFF_FFFFFFFF, then load B=0x00000000_00000000 during A's service, then consume continuously -> 128 consecutive valid bits (64 ones, then 64 zeros). No cycle with n_bit_valid_out=0. exp_done_out pulses at the 64th and 128th consumes.
- Backpressure: offer a third exponent while A is served and B sits in the shadow -> exp_ready_out=0. Blocks are not accepted until B is transferred. The accepted third exponent is served intact afterwards.
- Underrun: consume pulse with serve IDLE -> underrun_out=1 and stays 1 through a subsequent normal exponent. It is cleared only by rst_in.
- Reset mid-service: assert rst_in after 10 consumes of an exponent with a full shadow -> all outputs return to reset values. A freshly loaded exponent then starts at bit index 63.
